nibble_packer: RTL

- Upstream feeder for the combinational four-nibble descending sorter.
- Accepts a serial stream of 4-bit values over a valid/ready handshake and packs four of them into one 16-bit word.
- Presents each packed word from a registered output slot with its own valid/ready handshake; the sorter consumes out_data directly.
- Supports a flush that zero-pads a partial word. Zeros sort to the low nibbles, so padding never displaces real data from the top positions.

---
 rtl/nibble_packer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/nibble_packer.sv
// Packs a serial stream of W-bit elements into N-element words behind a
// registered output slot; flush closes a partial word with zero padding.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | assembly register has a free slot, in_ready=1
// FULL  | completed word waiting for the output slot, in_ready=0
module nibble_packer #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     in_flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*W-1:0]           out_data,
    output logic [$clog2(N+1)-1:0]   fill_level,
    output logic [7:0]               word_cnt
);

    localparam int DW = N * W;
    localparam int FW = $clog2(N + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   asm_q;
    logic [DW-1:0]   asm_nxt;
    logic [DW-1:0]   asm_wr;
    logic [FW-1:0]   fill_nxt;
    logic [DW-1:0]   load_word;
    logic            load;
    logic            accept;
    logic            slot_free;
    logic            handoff;
    logic            complete;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign handoff   = out_valid && out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        asm_wr    = asm_q;
        asm_nxt   = asm_q;
        fill_nxt  = fill_level;
        load      = 1'b0;
        load_word = asm_q;
        complete  = 1'b0;

        case (state)
            FILL: begin
                // Slot 0 sits in the top bits so the first element lands in the MSBs.
                for (int i = 0; i < N; i++) begin
                    if (accept && (fill_level == FW'(i))) begin
                        asm_wr[(N-1-i)*W +: W] = in_data;
                    end
                end

                complete = (accept && (fill_level == FW'(N - 1))) ||
                           (in_flush && ((fill_level != '0) || accept));

                if (complete) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_word = asm_wr;
                        asm_nxt   = '0;
                        fill_nxt  = '0;
                    end else begin
                        asm_nxt   = asm_wr;
                        fill_nxt  = FW'(N);
                        state_nxt = FULL;
                    end
                end else begin
                    asm_nxt  = asm_wr;
                    fill_nxt = fill_level + FW'(accept);
                end
            end

            FULL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = asm_q;
                    asm_nxt   = '0;
                    fill_nxt  = '0;
                    state_nxt = FILL;
                end
            end

            default: begin
                state_nxt = FILL;
                asm_nxt   = '0;
                fill_nxt  = '0;
            end
        endcase
    end

    // Cleared slots stay zero, which is what provides the flush padding.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            asm_q      <= '0;
            fill_level <= '0;
        end else begin
            asm_q      <= asm_nxt;
            fill_level <= fill_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_word;
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_cnt <= '0;
        end else if (handoff) begin
            word_cnt <= word_cnt + 8'd1;
        end
    end

endmodule
